// File: rtl/riscv_pkg.sv
// riscv_pkg: shared architectural constants for the integer register file
//   XLEN       register/data width
//   REG_ADDR_W register index width
//   NREGS      number of architectural registers
//   REG_ZERO   index of the hardwired-zero register x0
package riscv_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NREGS      = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one combinational read port of the register file
//   reset    forces the port to read 0 and suppresses forwarding
//   addr     source register index
//   regs     full register array contents
//   wb_data  write-back data presented this cycle
//   wb_addr  write-back destination index
//   wb_we    write-back enable
//   data     selected operand value
// Build option: REGFILE_WB_BYPASS_EN enables same-cycle write-back forwarding.
module regfile_read_port
    import riscv_pkg::*;
#(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int NREGS = riscv_pkg::NREGS
) (
    input  logic                       reset,
    input  logic [REG_ADDR_W-1:0]      addr,
    input  logic [NREGS-1:0][XLEN-1:0] regs,
    input  logic [XLEN-1:0]            wb_data,
    input  logic [REG_ADDR_W-1:0]      wb_addr,
    input  logic                       wb_we,
    output logic [XLEN-1:0]            data
);
`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    // x0 and reset win over forwarding, so a write aimed at x0 can never leak out.
    always_comb
        data = (reset || addr == REG_ZERO) ? '0 :
               (BYPASS && wb_we && wb_addr == addr) ? wb_data : regs[addr];
endmodule

// File: rtl/reg_file_wb.sv
// reg_file_wb: two-read, one-write integer register file with commit counter
//   clk          rising-edge clock
//   reset        asynchronous active-high reset; clears registers and counter
//   reg_data_wb  write-back data
//   reg_addr_wb  write-back destination index
//   reg_we_wb    write-back enable
//   rs1_addr     source 1 index
//   rs2_addr     source 2 index
//   rs1_data     source 1 value (combinational)
//   rs2_data     source 2 value (combinational)
//   wb_count     number of committed register writes, wraps at 2^32
// Build option: REGFILE_WB_BYPASS_EN forwards write-back data to matching read ports.
module reg_file_wb
    import riscv_pkg::*;
#(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int NREGS = riscv_pkg::NREGS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [XLEN-1:0]       reg_data_wb,
    input  logic [REG_ADDR_W-1:0] reg_addr_wb,
    input  logic                  reg_we_wb,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]       rs1_data,
    output logic [XLEN-1:0]       rs2_data,
    output logic [31:0]           wb_count
);
    logic [NREGS-1:0][XLEN-1:0] regs;
    logic                       commit;

    // x0 is never written, so it stays at its reset value of 0.
    assign commit = reg_we_wb && reg_addr_wb != REG_ZERO;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs     <= '0;
            wb_count <= '0;
        end else if (commit) begin
            regs[reg_addr_wb] <= reg_data_wb;
            wb_count          <= wb_count + 32'd1;
        end
    end

    regfile_read_port #(.XLEN(XLEN), .NREGS(NREGS)) u_rs1 (
        .reset   (reset),
        .addr    (rs1_addr),
        .regs    (regs),
        .wb_data (reg_data_wb),
        .wb_addr (reg_addr_wb),
        .wb_we   (reg_we_wb),
        .data    (rs1_data)
    );

    regfile_read_port #(.XLEN(XLEN), .NREGS(NREGS)) u_rs2 (
        .reset   (reset),
        .addr    (rs2_addr),
        .regs    (regs),
        .wb_data (reg_data_wb),
        .wb_addr (reg_addr_wb),
        .wb_we   (reg_we_wb),
        .data    (rs2_data)
    );
endmodule

// File: doc/reg_file_wb.md
REG_FILE_WB -- requirements
Module: reg_file_wb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of every register and data port.
REQ-002 SHALL have parameter NREGS, default 32, number of architectural registers; address width is log2(NREGS).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port reg_data_wb, input, XLEN, write-back data from the MEM/WB stage.
REQ-006 SHALL have port reg_addr_wb, input, 5, write-back destination register index.
REQ-007 SHALL have port reg_we_wb, input, 1, write-back enable.
REQ-008 SHALL have ports rs1_addr and rs2_addr, input, 5 each, decode-stage source indices.
REQ-009 SHALL have ports rs1_data and rs2_data, output, XLEN each, source operand values.
REQ-010 SHALL have port wb_count, output, 32, count of committed register writes.

Function
REQ-011 SHALL write reg_data_wb into register reg_addr_wb on the rising edge of clk when reg_we_wb=1 and reg_addr_wb!=0.
REQ-012 SHALL ignore every write to index 0; register 0 SHALL always read as 0.
REQ-013 SHALL drive rs1_data and rs2_data combinationally from rs1_addr and rs2_addr with zero-cycle latency.
REQ-014 SHALL return 0 on either read port when that port's address is 0, regardless of the write port.
REQ-015 SHALL support rs1_addr equal to rs2_addr; both ports return the identical value.
REQ-016 SHALL increment wb_count by 1 on each edge where the REQ-011 write condition holds; it wraps from 0xFFFFFFFF to 0.
REQ-017 SHALL NOT increment wb_count for writes to index 0 or when reg_we_wb=0.
REQ-018 SHALL treat reg_we_wb=1 with X/unknown address as a verification error; the bench flags it and the design does not detect it.

Reset
REQ-019 SHALL, while reset=1, asynchronously clear all NREGS registers and wb_count to 0.
REQ-020 SHALL block all writes while reset=1; a write pending at the edge reset asserts is discarded.
REQ-021 SHALL resume writes on the first rising clk edge after reset deasserts.
REQ-022 SHALL drive rs1_data and rs2_data to 0 for any address while reset=1, with bypass suppressed.

Configuration
REQ-023 SHALL use the macro REGFILE_WB_BYPASS_EN.
REQ-024 When REGFILE_WB_BYPASS_EN is defined, SHALL forward reg_data_wb to rsN_data in the same cycle if reg_we_wb=1, reg_addr_wb=rsN_addr, and rsN_addr!=0. This gives write-before-read semantics.
REQ-025 When REGFILE_WB_BYPASS_EN is undefined, SHALL return the pre-write stored value in that cycle and the new value from the next cycle. The hazard unit then covers the extra cycle.

Structure
REQ-026 SHALL take XLEN, REG_ADDR_W (5), NREGS (32) and the REG_ZERO index constant from the shared package riscv_pkg.
REQ-027 SHALL implement per-port read selection (zero check, bypass compare, array read) in one sub-module, regfile_read_port, instantiated twice.

Verification
REQ-028 Reset, then read all 32 indices -> every rs1_data/rs2_data = 0x00000000 and wb_count = 0.
REQ-029 Write 0xDEADBEEF to x5, then on the next cycle set rs1_addr=5 and rs2_addr=5 -> both ports = 0xDEADBEEF and wb_count = 1.
REQ-030 Write 0x12345678 to x0 with reg_we_wb=1, then read x0 -> 0x00000000 and wb_count unchanged.
REQ-031 Same cycle: write 0xCAFEF00D to x7 with rs1_addr=7 -> with bypass, rs1_data = 0xCAFEF00D that cycle; without bypass, it holds the old value, then 0xCAFEF00D on the next cycle.
REQ-032 Fill x1..x31 with 0x100+i, assert reset for half a clock period mid-sequence, then read -> all registers 0 and later writes land normally.
REQ-033 Preload wb_count to 0xFFFFFFFF via writes (force in bench), then one valid write -> wb_count = 0x00000000.
